// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one payload, then streams header, payload and parity bytes to a router port.
// Ports: clk, rst (sync, active-low); start/dest_addr/pay_len request a packet while tx_ready=1;
//        pay_data/pay_valid/pay_ready load the payload; busy stalls the router-side stream;
//        data_out/pkt_valid carry the stream; done pulses after the parity byte; reject pulses on a bad request.
// Optional: define PKT_TX_ERR_INJ_EN to add input err_inj, which corrupts bit 0 of the parity byte.
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pay_len,
`ifdef PKT_TX_ERR_INJ_EN
    input  logic       err_inj,
`endif
    input  logic [7:0] pay_data,
    input  logic       pay_valid,
    output logic       pay_ready,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       reject
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_PARITY  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [6:0] MAX_W     = 7'(MAX_LEN);

    logic [2:0] state_q, state_d;
    logic [5:0] len_q, len_d;
    logic [1:0] addr_q, addr_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] par_q, par_d;
    logic       rej_q, rej_d;
    logic       inj_q, inj_d;
    logic       inj_in;
    logic       bad_req;
    logic       last;
    logic [7:0] buf_q [MAX_LEN];

`ifdef PKT_TX_ERR_INJ_EN
    assign inj_in = err_inj;
`else
    assign inj_in = 1'b0;
`endif

    assign bad_req = (dest_addr == 2'd3) || (pay_len == 6'd0) || ({1'b0, pay_len} > MAX_W);
    // One counter serves as write index in FILL and read index in PAYLOAD.
    assign last    = cnt_q == len_q - 6'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        rej_d   = 1'b0;
        inj_d   = inj_q;
        case (state_q)
            S_IDLE: if (start) begin
                len_d  = pay_len;
                addr_d = dest_addr;
                if (bad_req) begin
                    rej_d = 1'b1;
                end else begin
                    state_d = S_FILL;
                    cnt_d   = 6'd0;
                    par_d   = {pay_len, dest_addr};
                    inj_d   = inj_in;
                end
            end
            S_FILL: if (pay_valid) begin
                cnt_d = last ? 6'd0 : cnt_q + 6'd1;
                par_d = par_q ^ pay_data;
                if (last) state_d = S_HEADER;
            end
            S_HEADER: if (!busy) state_d = S_PAYLOAD;
            S_PAYLOAD: if (!busy) begin
                cnt_d = last ? 6'd0 : cnt_q + 6'd1;
                if (last) state_d = S_PARITY;
            end
            S_PARITY: if (!busy) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= 6'd0;
            addr_q  <= 2'd0;
            cnt_q   <= 6'd0;
            par_q   <= 8'd0;
            rej_q   <= 1'b0;
            inj_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            rej_q   <= rej_d;
            inj_q   <= inj_d;
        end
    end

    // Payload storage needs no reset: it is always rewritten before being read.
    always_ff @(posedge clk) begin
        if (state_q == S_FILL && pay_valid) buf_q[cnt_q] <= pay_data;
    end

    assign tx_ready  = state_q == S_IDLE;
    assign pay_ready = state_q == S_FILL;
    assign pkt_valid = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
    assign done      = state_q == S_DONE;
    assign reject    = rej_q;
    assign data_out  = (state_q == S_HEADER)  ? {len_q, addr_q} :
                       (state_q == S_PAYLOAD) ? buf_q[cnt_q] :
                       (state_q == S_PARITY)  ? par_q ^ {7'd0, inj_q} : 8'd0;
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: drives directed and random packets and checks the byte stream against an expected-byte list.
module tb_router_pkt_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dest_addr = 2'd0;
    logic [5:0] pay_len = 6'd0;
    logic       err_inj = 1'b0;
    logic [7:0] pay_data = 8'd0;
    logic       pay_valid = 1'b0;
    logic       pay_ready;
    logic       busy = 1'b0;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_ready;
    logic       done;
    logic       reject;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] pay [64];

    router_pkt_tx #(.MAX_LEN(63)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dest_addr(dest_addr),
        .pay_len(pay_len),
`ifdef PKT_TX_ERR_INJ_EN
        .err_inj(err_inj),
`endif
        .pay_data(pay_data),
        .pay_valid(pay_valid),
        .pay_ready(pay_ready),
        .busy(busy),
        .data_out(data_out),
        .pkt_valid(pkt_valid),
        .tx_ready(tx_ready),
        .done(done),
        .reject(reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx_ready"}, tx_ready, 8'd1);
        chk({tag, "_pkt_valid"}, pkt_valid, 8'd0);
        chk({tag, "_data_out"}, data_out, 8'd0);
        chk({tag, "_pay_ready"}, pay_ready, 8'd0);
        chk({tag, "_done"}, done, 8'd0);
    endtask

    // Expected stream: header, payload bytes, parity (XOR of all of them, optionally bit-0 flipped).
    task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic inj,
                           input int stall_pct, input int gap_pct,
                           input int stall_idx, input int stall_n, input int abort_idx);
        logic [7:0] exp [$];
        logic [7:0] par;
        int idx, i, left;
        logic v, b;
        exp.delete();
        par = {l, a};
        exp.push_back(par);
        for (int k = 0; k < int'(l); k++) begin
            exp.push_back(pay[k]);
            par ^= pay[k];
        end
`ifdef PKT_TX_ERR_INJ_EN
        par ^= {7'd0, inj};
`endif
        exp.push_back(par);
        chk("pre_tx_ready", tx_ready, 8'd1);
        start = 1'b1; dest_addr = a; pay_len = l; err_inj = inj;
        @(negedge clk);
        start = 1'b0; dest_addr = 2'($urandom); pay_len = 6'($urandom); err_inj = 1'b0;
        chk("valid_no_reject", reject, 8'd0);
        i = 0;
        while (i < int'(l)) begin
            chk("fill_pay_ready", pay_ready, 8'd1);
            chk("fill_tx_ready", tx_ready, 8'd0);
            chk("fill_pkt_valid", pkt_valid, 8'd0);
            v = $urandom_range(99) >= gap_pct;
            pay_valid = v;
            pay_data = v ? pay[i] : 8'($urandom);
            busy = 1'($urandom);
            @(negedge clk);
            if (v) i++;
        end
        pay_valid = 1'b0;
        idx = 0;
        left = stall_n;
        while (idx <= int'(l) + 1) begin
            if (idx == abort_idx) begin
                start = 1'b0; pay_valid = 1'b0; busy = 1'b0; rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                chk_idle("abort");
                chk("abort_reject", reject, 8'd0);
                @(negedge clk);
                chk_idle("abort_after");
                return;
            end
            chk("stream_pkt_valid", pkt_valid, (idx <= int'(l)) ? 8'd1 : 8'd0);
            chk("stream_data", data_out, exp[idx]);
            chk("stream_pay_ready", pay_ready, 8'd0);
            chk("stream_done", done, 8'd0);
            b = (idx == stall_idx && left > 0) ? 1'b1 : ($urandom_range(99) < stall_pct);
            if (idx == stall_idx && left > 0) left--;
            busy = b;
            pay_valid = 1'($urandom);
            pay_data = 8'($urandom);
            start = 1'($urandom);
            dest_addr = 2'd1;
            pay_len = 6'd1;
            @(negedge clk);
            if (!b) idx++;
        end
        start = 1'b0; pay_valid = 1'b0; busy = 1'($urandom);
        chk("done_pulse", done, 8'd1);
        chk("done_data", data_out, 8'd0);
        chk("done_pkt_valid", pkt_valid, 8'd0);
        chk("done_tx_ready", tx_ready, 8'd0);
        @(negedge clk);
        busy = 1'b0;
        chk("post_done", done, 8'd0);
        chk("post_tx_ready", tx_ready, 8'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        chk("reset_reject", reject, 8'd0);
        rst = 1'b1;
        @(negedge clk);

        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_pkt(2'd1, 6'd3, 1'b0, 0, 0, -1, 0, -1);
        run_pkt(2'd1, 6'd3, 1'b0, 0, 0, 2, 3, -1);

        start = 1'b1; dest_addr = 2'd3; pay_len = 6'd3;
        @(negedge clk);
        start = 1'b0;
        chk("rej_addr_pulse", reject, 8'd1);
        chk("rej_addr_tx_ready", tx_ready, 8'd1);
        chk("rej_addr_pkt_valid", pkt_valid, 8'd0);
        @(negedge clk);
        chk("rej_addr_end", reject, 8'd0);
        chk("rej_addr_idle", tx_ready, 8'd1);
        start = 1'b1; dest_addr = 2'd0; pay_len = 6'd0;
        @(negedge clk);
        start = 1'b0;
        chk("rej_len_pulse", reject, 8'd1);
        chk("rej_len_pkt_valid", pkt_valid, 8'd0);
        @(negedge clk);
        chk("rej_len_end", reject, 8'd0);
        chk("rej_len_pay_ready", pay_ready, 8'd0);

        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        run_pkt(2'd0, 6'd4, 1'b0, 0, 0, -1, 0, 2);
        pay[0] = 8'hA5;
        run_pkt(2'd2, 6'd1, 1'b0, 0, 0, -1, 0, -1);

`ifdef PKT_TX_ERR_INJ_EN
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_pkt(2'd1, 6'd3, 1'b1, 0, 0, -1, 0, -1);
`endif

        pay[0] = 8'h5A;
        run_pkt(2'd0, 6'd63, 1'b0, 0, 0, -1, 0, -1);
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 64; k++) pay[k] = 8'($urandom);
            run_pkt(2'($urandom_range(2)), 6'($urandom_range(63, 1)), 1'($urandom), 30, 30, -1, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
